cache_req_queue: RTL and testbench

// - Upstream front-end of the data cache. Sits between the MIPS memory stage and Cache.
// - Buffers load/store requests in a small FIFO and issues them one at a time on the

---
 rtl/cache_req_pkg.sv | 20 ++
 rtl/req_fifo.sv | 46 ++++
 rtl/cache_req_queue.sv | 89 ++++++++
 tb/tb_cache_req_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_pkg.sv
// Shared types for the data-cache request queue: FSM state encoding and the queued request record.
package cache_req_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic              write;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    function automatic logic misaligned(input logic [ADDR_W-1:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// DEPTH-entry circular buffer of req_t; head_o is the oldest entry, count_o includes it.
module req_fifo
    import cache_req_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  req_t          din_i,
    output req_t          head_o,
    output logic [CW-1:0] count_o
);

    req_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cache_req_queue.sv
// Front-end of the data cache: queues CPU load/store requests, issues them one at a time
// to the cache, and returns one response per request over a valid/ready handshake.
module cache_req_queue
    import cache_req_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              c_ready,
    output logic              c_write_en,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data,
    input  logic              c_hit,
    input  logic [DATA_W-1:0] c_out,
    output logic [CW-1:0]     count
);

    state_t            state_q;
    req_t              din, head;
    logic [CW-1:0]     fifo_cnt;
    logic              push, pop;
    logic              resp_write_q, resp_err_q;
    logic [DATA_W-1:0] resp_data_q;

    assign din = '{write: req_write, err: misaligned(req_addr), addr: req_addr, data: req_data};

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign req_ready = en && reset && (fifo_cnt != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = en && (state_q == RESP) && resp_ready;

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .head_o  (head),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else if (en) begin
            case (state_q)
                // A push this cycle lands at the head, so issue starts the very next cycle.
                IDLE:  if (fifo_cnt != '0 || push) state_q <= ISSUE;
                ISSUE: if (c_hit) begin
                    resp_data_q  <= head.write ? head.data : c_out;
                    resp_write_q <= head.write;
                    resp_err_q   <= head.err;
                    state_q      <= RESP;
                end
                RESP:  if (resp_ready) state_q <= (fifo_cnt > CW'(1) || push) ? ISSUE : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Head stays put until the pop in RESP, so the cache port is stable through ISSUE.
    assign c_ready    = (state_q == ISSUE);
    assign c_write_en = c_ready && head.write;
    assign c_addr     = c_ready ? {head.addr[ADDR_W-1:2], 2'b00} : '0;
    assign c_data     = c_ready ? head.data : '0;

    assign resp_valid = (state_q == RESP);
    assign resp_write = resp_write_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign count      = fifo_cnt;

endmodule

// File: tb/tb_cache_req_queue.sv
// Scoreboard bench for cache_req_queue with a small latency-programmable cache model.
module tb_cache_req_queue;

    logic        clk = 1'b0;
    logic        reset, en, req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_data;
    logic        resp_valid, resp_ready, resp_write, resp_err;
    logic [31:0] resp_data;
    logic        c_ready, c_write_en, c_hit;
    logic [31:0] c_addr, c_data, c_out;
    logic [2:0]  count;

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hit_delay = 0;
    int   wait_cnt = 0;

    always #5 clk = ~clk;

    cache_req_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_data(resp_data), .resp_err(resp_err),
        .c_ready(c_ready), .c_write_en(c_write_en), .c_addr(c_addr), .c_data(c_data),
        .c_hit(c_hit), .c_out(c_out), .count(count)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    // Cache model: hits after hit_delay waiting cycles, frozen by en like the real cache.
    always @(posedge clk) begin
        if (en) wait_cnt <= (c_ready && !c_hit) ? wait_cnt + 1 : 0;
    end
    assign c_hit = c_ready && (wait_cnt >= hit_delay);
    assign c_out = c_ready ? memval(c_addr) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: accepted requests feed the scoreboard, handshaken responses drain it.
    always @(negedge clk) begin : mon
        exp_t e;
        if (req_valid && req_ready) begin
            e.w = req_write;
            e.e = (req_addr[1:0] != 2'b00);
            e.d = req_write ? req_data : memval({req_addr[31:2], 2'b00});
            exp_q.push_back(e);
        end
        if (en && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
            else begin
                e = exp_q.pop_front();
                chk("resp_write", 64'(resp_write), 64'(e.w));
                chk("resp_data",  64'(resp_data),  64'(e.d));
                chk("resp_err",   64'(resp_err),   64'(e.e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        while (!req_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("send_timeout", 64'(0), 64'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (!resp_valid && n < 100) begin tick(); n++; end
        chk(tag, 64'(resp_valid), 64'(1));
    endtask

    task automatic take();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        resp_ready = 1'b1;
        while ((count != 0 || resp_valid) && n < 200) begin tick(); n++; end
        resp_ready = 1'b0;
        chk(tag, 64'(count), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; en = 1'b1; resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h44; req_data = 32'h0;

        // Reset with a pending request
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_count",     64'(count),     64'(0));
        chk("rst_c_ready",   64'(c_ready),   64'(0));
        chk("rst_resp_vld",  64'(resp_valid), 64'(0));
        chk("rst_c_addr",    64'(c_addr),    64'(0));
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        tick();

        // Single load, immediate hit
        hit_delay = 0;
        send(1'b0, 32'h10, 32'h0);
        chk("ld_c_ready", 64'(c_ready),    64'(1));
        chk("ld_c_addr",  64'(c_addr),     64'(32'h10));
        chk("ld_c_we",    64'(c_write_en), 64'(0));
        tick();
        chk("ld_resp_vld",  64'(resp_valid), 64'(1));
        chk("ld_resp_data", 64'(resp_data),  64'(32'hDEAD_BEEF));
        take();
        chk("ld_idle_cnt", 64'(count),      64'(0));
        chk("ld_idle_vld", 64'(resp_valid), 64'(0));

        // Store with hit delayed 5 cycles: cache port stable for 6 cycles
        hit_delay = 5;
        send(1'b1, 32'h20, 32'h1234);
        for (int i = 0; i < 6; i++) begin
            chk("st_c_ready", 64'(c_ready),    64'(1));
            chk("st_c_we",    64'(c_write_en), 64'(1));
            chk("st_c_addr",  64'(c_addr),     64'(32'h20));
            chk("st_c_data",  64'(c_data),     64'(32'h1234));
            tick();
        end
        chk("st_resp_vld",  64'(resp_valid), 64'(1));
        chk("st_resp_data", 64'(resp_data),  64'(32'h1234));
        chk("st_resp_wr",   64'(resp_write), 64'(1));
        take();

        // Misaligned load
        hit_delay = 0;
        send(1'b0, 32'h13, 32'h0);
        chk("mis_c_addr", 64'(c_addr), 64'(32'h10));
        tick();
        chk("mis_err", 64'(resp_err), 64'(1));
        take();

        // Fill to DEPTH with responses stalled, fifth waits for the first pop
        send(1'b0, 32'h100, 32'h0);
        send(1'b1, 32'h104, 32'hAAAA_0001);
        send(1'b0, 32'h108, 32'h0);
        send(1'b1, 32'h10C, 32'hAAAA_0003);
        chk("full_cnt",   64'(count),     64'(4));
        chk("full_ready", 64'(req_ready), 64'(0));
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h110; req_data = 32'h0;
        tick(); tick();
        chk("full_hold_ready", 64'(req_ready), 64'(0));
        chk("full_hold_cnt",   64'(count),     64'(4));
        resp_ready = 1'b1;
        begin
            int n = 0;
            while (!req_ready && n < 50) begin tick(); n++; end
        end
        chk("fifth_after_pop", 64'(count), 64'(3));
        tick();
        req_valid = 1'b0;
        drain("full_drain");

        // Simultaneous push and pop leaves count unchanged
        send(1'b0, 32'h200, 32'h0);
        wait_resp("pp_resp");
        chk("pp_cnt_before", 64'(count), 64'(1));
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h204; req_data = 32'h5555;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("pp_cnt_after", 64'(count),   64'(1));
        chk("pp_c_ready",   64'(c_ready), 64'(1));
        chk("pp_c_addr",    64'(c_addr),  64'(32'h204));
        drain("pp_drain");

        // Enable dropped mid-ISSUE
        hit_delay = 3;
        send(1'b0, 32'h40, 32'h0);
        tick();
        en = 1'b0;
        #1;
        chk("en_req_ready", 64'(req_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_c_ready", 64'(c_ready),    64'(1));
            chk("en_c_addr",  64'(c_addr),     64'(32'h40));
            chk("en_count",   64'(count),      64'(1));
            chk("en_resp",    64'(resp_valid), 64'(0));
        end
        en = 1'b1;
        wait_resp("en_resp_done");
        chk("en_resp_data", 64'(resp_data), 64'(memval(32'h40)));
        take();

        // Reset asserted while a response is pending
        hit_delay = 0;
        send(1'b0, 32'h50, 32'h0);
        tick();
        chk("rr_resp_vld", 64'(resp_valid), 64'(1));
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("rr_drop_vld", 64'(resp_valid), 64'(0));
        chk("rr_drop_cnt", 64'(count),      64'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("rr_after_vld",   64'(resp_valid), 64'(0));
        chk("rr_after_c_rdy", 64'(c_ready),    64'(0));
        chk("rr_after_ready", 64'(req_ready),  64'(1));

        chk("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
